// File: rtl/lcd_timing_pkg.sv
// rtl/lcd_timing_pkg.sv - default LCD timing constants, pixel struct and colour-bar helper
package lcd_timing_pkg;

  // 640x480 panel timing, counts in pixel clocks / lines
  localparam int H_TOTAL_DEF  = 1056;
  localparam int H_SYNC_DEF   = 1;
  localparam int H_START_DEF  = 216;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_TOTAL_DEF  = 525;
  localparam int V_SYNC_DEF   = 1;
  localparam int V_START_DEF  = 35;
  localparam int V_ACTIVE_DEF = 480;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Bars in order white, yellow, cyan, green, magenta, red, blue, black
  function automatic rgb_t bar_rgb(input logic [2:0] idx);
    rgb_t c;
    c.r = idx[1] ? 8'h00 : 8'hFF;
    c.g = idx[2] ? 8'h00 : 8'hFF;
    c.b = idx[0] ? 8'h00 : 8'hFF;
    return c;
  endfunction

endpackage

// File: rtl/lcd_hv_counter.sv
// rtl/lcd_hv_counter.sv - half-rate pixel enable, H/V counters, syncs and window decode
module lcd_hv_counter
  import lcd_timing_pkg::*;
#(
  parameter int H_TOTAL  = H_TOTAL_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_START  = H_START_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_TOTAL  = V_TOTAL_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_START  = V_START_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_i,
  output logic        clock_en_o,
  output logic [10:0] h_count_o,
  output logic [9:0]  v_count_o,
  output logic        hsync_n_o,
  output logic        vsync_n_o,
  output logic        frame_start_o,
  output logic        active_o,
  output logic        read_win_o
);

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_SYNC_C = 11'(H_SYNC);
  localparam logic [10:0] H_BEG    = 11'(H_START);
  localparam logic [10:0] H_END    = 11'(H_START + H_ACTIVE);
  // Reads run one count ahead of the displayed window
  localparam logic [10:0] H_RD_BEG = 11'(H_START - 1);
  localparam logic [10:0] H_RD_END = 11'(H_START + H_ACTIVE - 2);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_SYNC_C = 10'(V_SYNC);
  localparam logic [9:0]  V_BEG    = 10'(V_START);
  localparam logic [9:0]  V_END    = 10'(V_START + V_ACTIVE);

  logic        ce_q;
  logic [10:0] h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic        hs_n_q, vs_n_q, fs_q;
  logic        h_wrap, v_wrap, v_act;

  // Next counter values; they only move on pixel-enable cycles
  always_comb begin
    h_wrap = (h_q == H_LAST);
    v_wrap = (v_q == V_LAST);
    h_d    = h_q;
    v_d    = v_q;
    if (ce_q) begin
      h_d = h_wrap ? 11'd0 : h_q + 11'd1;
      if (h_wrap) begin
        v_d = v_wrap ? 10'd0 : v_q + 10'd1;
      end
    end
  end

  // Counter, sync and frame-start registers; Enable low clears everything
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ce_q   <= 1'b0;
      h_q    <= '0;
      v_q    <= '0;
      hs_n_q <= 1'b1;
      vs_n_q <= 1'b1;
      fs_q   <= 1'b0;
    end else if (!enable_i) begin
      ce_q   <= 1'b0;
      h_q    <= '0;
      v_q    <= '0;
      hs_n_q <= 1'b1;
      vs_n_q <= 1'b1;
      fs_q   <= 1'b0;
    end else begin
      ce_q <= ~ce_q;
      h_q  <= h_d;
      v_q  <= v_d;
      if (ce_q) begin
        hs_n_q <= !(h_d < H_SYNC_C);
        vs_n_q <= !(v_d < V_SYNC_C);
      end
      fs_q <= ce_q & h_wrap & v_wrap;
    end
  end

  // Active-window and read-window decode on the current counts
  always_comb begin
    v_act      = (v_q >= V_BEG) && (v_q < V_END);
    active_o   = v_act && (h_q >= H_BEG) && (h_q < H_END);
    read_win_o = v_act && (h_q >= H_RD_BEG) && (h_q <= H_RD_END);
  end

  assign clock_en_o    = ce_q;
  assign h_count_o     = h_q;
  assign v_count_o     = v_q;
  assign hsync_n_o     = hs_n_q;
  assign vsync_n_o     = vs_n_q;
  assign frame_start_o = fs_q;

endmodule

// File: rtl/lcd_timing_reader.sv
// rtl/lcd_timing_reader.sv - LCD timing master and pixel reader; LCD_TEST_PATTERN_EN adds colour bars
module lcd_timing_reader
  import lcd_timing_pkg::*;
#(
  parameter int H_TOTAL  = H_TOTAL_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_START  = H_START_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_TOTAL  = V_TOTAL_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_START  = V_START_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Enable,
  output logic        Clock_en,
  output logic [10:0] H_Count,
  output logic [9:0]  V_Count,
  output logic        oRead_out_en,
  input  logic [7:0]  R_in,
  input  logic [7:0]  G_in,
  input  logic [7:0]  B_in,
`ifdef LCD_TEST_PATTERN_EN
  input  logic        Test_pattern,
`endif
  output logic [7:0]  LCD_R,
  output logic [7:0]  LCD_G,
  output logic [7:0]  LCD_B,
  output logic        LCD_HSYNC_n,
  output logic        LCD_VSYNC_n,
  output logic        LCD_DEN,
  output logic        oFrame_start
);

  logic active, read_win;
  rgb_t pix_d, rgb_q;
  logic den_q;

  lcd_hv_counter #(
    .H_TOTAL (H_TOTAL),
    .H_SYNC  (H_SYNC),
    .H_START (H_START),
    .H_ACTIVE(H_ACTIVE),
    .V_TOTAL (V_TOTAL),
    .V_SYNC  (V_SYNC),
    .V_START (V_START),
    .V_ACTIVE(V_ACTIVE)
  ) u_hv (
    .clk_i        (Clock),
    .rst_ni       (Resetn),
    .enable_i     (Enable),
    .clock_en_o   (Clock_en),
    .h_count_o    (H_Count),
    .v_count_o    (V_Count),
    .hsync_n_o    (LCD_HSYNC_n),
    .vsync_n_o    (LCD_VSYNC_n),
    .frame_start_o(oFrame_start),
    .active_o     (active),
    .read_win_o   (read_win)
  );

  // Strobe is combinational so it drops the same cycle Enable falls
  assign oRead_out_en = Enable & Clock_en & read_win;

`ifdef LCD_TEST_PATTERN_EN
  localparam int          BAR_W   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  localparam logic [10:0] H_BEG   = 11'(H_START);
  localparam logic [10:0] BAR_W_C = 11'(BAR_W);

  logic [10:0] col, bar;
  logic [2:0]  bar_idx;

  // Pixel source: colour bar from the column, or the filter pipe data
  always_comb begin
    col     = H_Count - H_BEG;
    bar     = col / BAR_W_C;
    bar_idx = (bar > 11'd7) ? 3'd7 : bar[2:0];
    if (Test_pattern) begin
      pix_d = bar_rgb(bar_idx);
    end else begin
      pix_d.r = R_in;
      pix_d.g = G_in;
      pix_d.b = B_in;
    end
  end
`else
  // Pixel source: filter pipe data
  always_comb begin
    pix_d.r = R_in;
    pix_d.g = G_in;
    pix_d.b = B_in;
  end
`endif

  // Capture the pixel read one count earlier; blank to black outside the window
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      den_q <= 1'b0;
      rgb_q <= '0;
    end else if (!Enable) begin
      den_q <= 1'b0;
      rgb_q <= '0;
    end else if (Clock_en) begin
      den_q <= active;
      rgb_q <= active ? pix_d : '0;
    end
  end

  assign LCD_DEN = den_q;
  assign LCD_R   = rgb_q.r;
  assign LCD_G   = rgb_q.g;
  assign LCD_B   = rgb_q.b;

endmodule

// File: doc/lcd_timing_reader.md
Name: lcd_timing_reader

Overview:
- Display-side timing master and pixel reader for the LCD path.
- Generates the half-rate pixel enable, H/V counters, syncs and data-enable for a 640x480 active window.
- Issues the per-pixel read strobe that pulls filtered pixels out of the filter pipe's output line buffer, and drives registered RGB to the LCD.
- Sits between the filter pipe's output port (R/G/B out, read-enable in) and the LCD pins; its counters also feed the filter pipe's H_Count/V_Count inputs.

Parameters:
- H_TOTAL, 1056, pixel clocks per line (counter wraps at H_TOTAL-1)
- H_SYNC, 1, HSYNC_n low width in pixel clocks from H_Count 0
- H_START, 216, first active column count
- H_ACTIVE, 640, active columns
- V_TOTAL, 525, lines per frame
- V_SYNC, 1, VSYNC_n low width in lines from V_Count 0
- V_START, 35, first active line count
- V_ACTIVE, 480, active lines

Ports:
- Clock  in  1  system clock
- Resetn  in  1  asynchronous active-low reset
- Enable  in  1  run; low = synchronous clear of all state
- Clock_en  out  1  pixel enable, toggles every Clock while Enable
- H_Count  out  11  horizontal count
- V_Count  out  10  vertical count
- oRead_out_en  out  1  pixel read strobe to filter pipe (its iRead_out_en)
- R_in  in  8  red pixel from filter pipe
- G_in  in  8  green pixel from filter pipe
- B_in  in  8  blue pixel from filter pipe
- LCD_R  out  8  registered red to LCD
- LCD_G  out  8  registered green to LCD
- LCD_B  out  8  registered blue to LCD
- LCD_HSYNC_n  out  1  horizontal sync, active low
- LCD_VSYNC_n  out  1  vertical sync, active low
- LCD_DEN  out  1  data enable
- oFrame_start  out  1  one-Clock pulse at start of each frame

Behaviour:
- Reset: Clock_en=0, H_Count=0, V_Count=0, oRead_out_en=0, LCD_R/G/B=0, HSYNC_n=1, VSYNC_n=1, DEN=0, oFrame_start=0.
- Enable low: same values applied synchronously on the next Clock.
- Enable high: Clock_en toggles every Clock, starting at 1 on the first enabled cycle.
- All counters and LCD registers update only on Clock edges where Clock_en=1.
- H_Count increments and wraps H_TOTAL-1 -> 0. V_Count increments only on the H wrap, and wraps V_TOTAL-1 -> 0.
- HSYNC_n is registered low when the next H_Count is < H_SYNC. VSYNC_n is registered low when the next V_Count is < V_SYNC. Both are aligned with the counters.
- Active region: H_START <= H_Count < H_START+H_ACTIVE and V_START <= V_Count < V_START+V_ACTIVE.
- oRead_out_en is combinational: Enable & Clock_en & (V_Count in active lines) & (H_START-1 <= H_Count <= H_START+H_ACTIVE-2). This gives exactly 640 one-Clock strobes per active line.
- R_in/G_in/B_in are valid the Clock after a strobe and are captured on the next Clock_en edge.
- LCD_DEN and LCD_R/G/B are registered. Pixel x (0..639) appears while H_Count == H_START+x+1, and DEN=1 on exactly those 640 counts.
- Outside DEN, RGB is forced to 0.
- oFrame_start = 1 for one Clock when H_Count and V_Count both wrap to 0.
- Enable deasserted mid-line: strobes stop immediately and counters restart from 0. The filter pipe's read address is cleared by the same Enable, so no realignment is needed.
- Widths: comparisons are done at counter width; parameters must satisfy H_START+H_ACTIVE < H_TOTAL and V_START+V_ACTIVE < V_TOTAL.

Optional Feature:
- Macro LCD_TEST_PATTERN_EN.
- Defined: adds input Test_pattern (1 bit). When high, LCD_R/G/B show 8 vertical colour bars, each 80 columns wide, in order white, yellow, cyan, green, magenta, red, blue, black (components 8'hFF or 8'h00). Strobes are still issued, so the filter pipe drains normally.
- Undefined: the port is absent and pixels always come from R_in/G_in/B_in.

Decomposition:
- Package lcd_timing_pkg: default timing constants and an rgb_t packed struct (r, g, b, 8 bits each).
- One sub-module, lcd_hv_counter: Clock_en generation, H/V counters, sync and active-window decode.
- lcd_timing_reader itself: strobe, capture register, blanking and test pattern.

Test Plan:
- Reset release, Enable=1 -> Clock_en alternates from cycle 1; H_Count reaches 1055 then 0; V_Count increments at each wrap; one frame = 1056*525*2 Clocks.
- Count strobes across one active line -> exactly 640; first at H_Count=215, last at 854; none on lines 0..34 or 515..524.
- Feed R_in = column index low byte -> LCD_R=0 at H_Count=217 (pixel 0), 8'd127 at H_Count=344 (pixel 127); DEN high for counts 217..856 only.
- Sync check -> HSYNC_n low only at H_Count 0; VSYNC_n low only during V_Count 0; oFrame_start single pulse per 1108800 Clocks.
- Drop Enable at H_Count=400, V_Count=100 for 5 Clocks -> all outputs at reset values next Clock; restart from H_Count=0, V_Count=0.
- LCD_TEST_PATTERN_EN defined, Test_pattern=1 -> pixel 0 = FF/FF/FF, pixel 80 = FF/FF/00, pixel 639 = 00/00/00; strobe count still 640.
